spi_write_controller: RTL and testbench

- SPI Mode 0 controller: the initiating end of the onboarding SPI register-write link.
- Serialises one 16-bit frame per accepted command, MSB first: [15] rw, [14:8] addr, [7:0] data.
- Drives sclk/copi/ncs into the peripheral-side register file; used in the bring-up harness and as the on-chip loopback stimulus for the peripheral.
- Write-only; no cipo path.

---
 rtl/spi_frame_pkg.sv | 28 ++
 rtl/spi_sclk_div.sv | 43 ++++
 rtl/spi_write_controller.sv | 145 ++++++++++++++
 tb/tb_spi_write_controller.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_frame_pkg.sv
// spi_frame_pkg
//   Shared definitions for the onboarding SPI register-write link: frame
//   geometry, controller state encoding and the frame-pack helper that the
//   peripheral-side decoder also uses.
package spi_frame_pkg;

  localparam int FRAME_BITS = 16;
  localparam int ADDR_W     = 7;
  localparam int DATA_W     = 8;
  localparam logic RW_WRITE = 1'b1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    SHIFT = 2'd2,
    GAP   = 2'd3
  } spi_state_e;

  // Frame layout, MSB first on the wire: [15] rw, [14:8] addr, [7:0] data.
  function automatic logic [FRAME_BITS-1:0] pack_frame(
    input logic              rw,
    input logic [ADDR_W-1:0] addr,
    input logic [DATA_W-1:0] data
  );
    return {rw, addr, data};
  endfunction

endpackage

// File: rtl/spi_sclk_div.sv
// spi_sclk_div
//   Half-period tick generator for the SPI clock. A counter runs 0..CLK_DIV-1;
//   each terminal count ends one sclk half-period. The phase bit alternates
//   the tick between rise_tick (end of a low half) and fall_tick (end of a
//   high half). restart returns to the start of a low half-period.
//
// Ports
//   clk        system clock
//   rst        synchronous active-high reset
//   restart    restart counting from the beginning of a low half-period
//   rise_tick  sclk should go high at the next edge
//   fall_tick  sclk should go low at the next edge
module spi_sclk_div #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic restart,
  output logic rise_tick,
  output logic fall_tick
);

  logic [7:0] div_cnt;
  logic       phase;
  logic       term_cnt;

  assign term_cnt  = (div_cnt == 8'(CLK_DIV - 1));
  assign rise_tick = term_cnt & ~phase;
  assign fall_tick = term_cnt & phase;

  always_ff @(posedge clk) begin
    if (rst || restart) begin
      div_cnt <= '0;
      phase   <= 1'b0;
    end else if (term_cnt) begin
      div_cnt <= '0;
      phase   <= ~phase;
    end else begin
      div_cnt <= div_cnt + 8'd1;
    end
  end

endmodule

// File: rtl/spi_write_controller.sv
// spi_write_controller
//   SPI mode 0 initiator for the register-write link. Each accepted command
//   is packed into a 16-bit frame and shifted out MSB first on copi, with
//   ncs framing and sclk idle low. Write-only: there is no cipo path.
//
// Ports
//   clk        system clock
//   rst        synchronous active-high reset
//   cmd_valid  command request
//   cmd_ready  command accepted when cmd_valid & cmd_ready at a clk edge
//   cmd_rw     frame bit 15
//   cmd_addr   frame bits 14:8
//   cmd_data   frame bits 7:0
//   sclk       SPI clock, idle low
//   copi       SPI data to peripheral
//   ncs        chip select, active low
//   busy       high from acceptance until cmd_ready returns
//   done       one-cycle pulse at frame completion
//
// state | meaning
// IDLE  | cmd_ready high, waiting for a command
// SETUP | ncs low, bit 15 on copi, waiting one half-period before first rise
// SHIFT | 16 sclk periods; copi advances on each fall; final low half is hold
// GAP   | ncs high, enforcing minimum deselect time before the next command
module spi_write_controller
  import spi_frame_pkg::*;
#(
  parameter int CLK_DIV    = 4,
  parameter int GAP_CYCLES = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_rw,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_data,
  output logic              sclk,
  output logic              copi,
  output logic              ncs,
  output logic              busy,
  output logic              done
);

  spi_state_e            state;
  logic [FRAME_BITS-1:0] shift_reg;
  logic [3:0]            bit_cnt;
  logic                  tail;
  logic [7:0]            gap_cnt;
  logic                  accept;
  logic                  rise_tick;
  logic                  fall_tick;

  assign accept = (state == IDLE) && cmd_valid && !rst;

  spi_sclk_div #(
    .CLK_DIV(CLK_DIV)
  ) u_sclk_div (
    .clk      (clk),
    .rst      (rst),
    .restart  (accept),
    .rise_tick(rise_tick),
    .fall_tick(fall_tick)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      shift_reg <= '0;
      bit_cnt   <= '0;
      tail      <= 1'b0;
      gap_cnt   <= '0;
      sclk      <= 1'b0;
      copi      <= 1'b0;
      ncs       <= 1'b1;
      cmd_ready <= 1'b1;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            shift_reg <= pack_frame(cmd_rw, cmd_addr, cmd_data);
            copi      <= cmd_rw;
            ncs       <= 1'b0;
            sclk      <= 1'b0;
            busy      <= 1'b1;
            cmd_ready <= 1'b0;
            bit_cnt   <= '0;
            tail      <= 1'b0;
            state     <= SETUP;
          end
        end

        SETUP: begin
          if (rise_tick) begin
            sclk  <= 1'b1;
            state <= SHIFT;
          end
        end

        SHIFT: begin
          if (fall_tick) begin
            sclk <= 1'b0;
            if (bit_cnt == 4'd15) begin
              copi <= 1'b0;
              tail <= 1'b1;
            end else begin
              // Rotate so the register always holds the next bit at [14];
              // the bit already on the wire wraps harmlessly to the bottom.
              copi      <= shift_reg[FRAME_BITS-2];
              shift_reg <= {shift_reg[FRAME_BITS-2:0], shift_reg[FRAME_BITS-1]};
              bit_cnt   <= bit_cnt + 4'd1;
            end
          end else if (rise_tick) begin
            // After the last bit, the would-be 17th rise marks the end of
            // the ncs hold half-period.
            if (tail) begin
              ncs     <= 1'b1;
              done    <= 1'b1;
              gap_cnt <= 8'(GAP_CYCLES - 1);
              state   <= GAP;
            end else begin
              sclk <= 1'b1;
            end
          end
        end

        GAP: begin
          if (gap_cnt == 8'd0) begin
            cmd_ready <= 1'b1;
            busy      <= 1'b0;
            state     <= IDLE;
          end else begin
            gap_cnt <= gap_cnt - 8'd1;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_write_controller.sv
// tb_spi_write_controller
//   Two controller instances (CLK_DIV=4 and CLK_DIV=1) driven by randomized
//   and directed commands. A wire-level monitor reconstructs each frame from
//   copi at sclk rising edges and checks timing against the frame formulas.
module tb_spi_write_controller;

  localparam int D0  = 4;
  localparam int D1  = 1;
  localparam int GAP = 4;

  typedef struct {
    int          cyc;
    int          start;
    int          nrise;
    int          rise_cyc;
    int          last_gap;
    int          dones;
    logic [15:0] sh;
    logic [15:0] frame;
    logic        p_ncs;
    logic        p_sclk;
    logic        p_copi;
    logic        p_ready;
    bit          active;
    bit          aborted;
    bit          fin;
  } mon_t;

  logic       clk = 1'b0;
  logic       rst_w    [2];
  logic       cv       [2];
  logic       rw_v     [2];
  logic [6:0] addr_v   [2];
  logic [7:0] data_v   [2];
  logic       rdy      [2];
  logic       sclk_w   [2];
  logic       copi_w   [2];
  logic       ncs_w    [2];
  logic       busy_w   [2];
  logic       done_w   [2];

  int          n_checks = 0;
  int          n_errors = 0;
  int          n_frames [2];
  bit          mon_en = 1'b0;
  mon_t        st0, st1;
  logic [15:0] exp0[$];
  logic [15:0] exp1[$];

  always #5 clk = ~clk;

  spi_write_controller #(.CLK_DIV(D0), .GAP_CYCLES(GAP)) u_dut0 (
    .clk(clk), .rst(rst_w[0]), .cmd_valid(cv[0]), .cmd_ready(rdy[0]),
    .cmd_rw(rw_v[0]), .cmd_addr(addr_v[0]), .cmd_data(data_v[0]),
    .sclk(sclk_w[0]), .copi(copi_w[0]), .ncs(ncs_w[0]),
    .busy(busy_w[0]), .done(done_w[0])
  );

  spi_write_controller #(.CLK_DIV(D1), .GAP_CYCLES(GAP)) u_dut1 (
    .clk(clk), .rst(rst_w[1]), .cmd_valid(cv[1]), .cmd_ready(rdy[1]),
    .cmd_rw(rw_v[1]), .cmd_addr(addr_v[1]), .cmd_data(data_v[1]),
    .sclk(sclk_w[1]), .copi(copi_w[1]), .ncs(ncs_w[1]),
    .busy(busy_w[1]), .done(done_w[1])
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference timing, relative to the cycle ncs falls:
  //   rise k at d*(1+2k), ncs high at 33d, cmd_ready back at 33d+GAP.
  task automatic mon(input int d, input logic ncs, input logic sclk, input logic copi,
                     input logic done, input logic ready, input logic busy,
                     input logic rst, inout mon_t s);
    bit fell, rose;
    s.fin = 1'b0;
    s.cyc++;
    fell = s.p_ncs && !ncs;
    rose = !s.p_ncs && ncs;
    if (done) s.dones++;
    check("busy_vs_ready", busy, !ready);
    if (fell) begin
      if (s.rise_cyc >= 0) s.last_gap = s.cyc - s.rise_cyc;
      s.start   = s.cyc;
      s.nrise   = 0;
      s.sh      = '0;
      s.active  = 1'b1;
      s.aborted = 1'b0;
    end
    if (copi !== s.p_copi)
      check("copi_moves_only_on_fall", (s.p_sclk && !sclk) || fell || rst, 1'b1);
    if (!s.p_sclk && sclk && !ncs) begin
      check("rise_time", s.cyc - s.start, d * (1 + 2 * s.nrise));
      s.sh = {s.sh[14:0], copi};
      s.nrise++;
    end
    if (rose && s.active) begin
      s.active   = 1'b0;
      s.rise_cyc = s.cyc;
      if (rst) begin
        check("abort_no_done", done, 1'b0);
        s.aborted = 1'b1;
      end else begin
        check("ncs_low_len", s.cyc - s.start, 33 * d);
        check("done_at_end", done, 1'b1);
        check("rise_count", s.nrise, 16);
        check("copi_idle_at_end", copi, 1'b0);
        check("sclk_idle_at_end", sclk, 1'b0);
        s.fin   = 1'b1;
        s.frame = s.sh;
      end
    end
    if (!s.p_ready && ready && !s.aborted && !rst)
      check("ready_time", s.cyc - s.start, 33 * d + GAP);
    s.p_ncs   = ncs;
    s.p_sclk  = sclk;
    s.p_copi  = copi;
    s.p_ready = ready;
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      mon(D0, ncs_w[0], sclk_w[0], copi_w[0], done_w[0], rdy[0], busy_w[0], rst_w[0], st0);
      if (st0.fin) begin
        check("frame_expected_0", exp0.size() != 0, 1'b1);
        if (exp0.size() != 0) check("frame_0", st0.frame, exp0.pop_front());
      end
      mon(D1, ncs_w[1], sclk_w[1], copi_w[1], done_w[1], rdy[1], busy_w[1], rst_w[1], st1);
      if (st1.fin) begin
        check("frame_expected_1", exp1.size() != 0, 1'b1);
        if (exp1.size() != 0) check("frame_1", st1.frame, exp1.pop_front());
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Presents a command and waits for its acceptance edge. cmd_valid is left
  // high so back-to-back callers can chain; the caller drops it.
  task automatic send(input int w, input logic rw, input logic [6:0] a,
                      input logic [7:0] dt, input bit push);
    bit          rb;
    bit          ok = 1'b0;
    int          n  = 0;
    logic [15:0] f;
    f = {rw, a, dt};
    cv[w] = 1'b1; rw_v[w] = rw; addr_v[w] = a; data_v[w] = dt;
    while (!ok && n < 400) begin
      rb = rdy[w];
      tick(1);
      n++;
      if (rb) ok = 1'b1;
    end
    check("accept_in_time", ok, 1'b1);
    if (ok) begin
      check("start_ncs", ncs_w[w], 1'b0);
      check("start_copi", copi_w[w], f[15]);
      check("start_sclk", sclk_w[w], 1'b0);
      check("start_busy", busy_w[w], 1'b1);
      check("start_ready", rdy[w], 1'b0);
      if (push) begin
        if (w == 0) exp0.push_back(f); else exp1.push_back(f);
        n_frames[w]++;
      end
    end
  endtask

  task automatic wait_idle(input int w);
    int n = 0;
    while (!rdy[w] && n < 400) begin
      tick(1);
      n++;
    end
    check("idle_in_time", rdy[w], 1'b1);
  endtask

  task automatic check_idle(input int w, input string tag);
    check({tag, "_sclk"}, sclk_w[w], 1'b0);
    check({tag, "_copi"}, copi_w[w], 1'b0);
    check({tag, "_ncs"}, ncs_w[w], 1'b1);
    check({tag, "_ready"}, rdy[w], 1'b1);
    check({tag, "_busy"}, busy_w[w], 1'b0);
    check({tag, "_done"}, done_w[w], 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int d_before;
    st0 = '{default: 0};
    st1 = '{default: 0};
    st0.rise_cyc = -1; st0.p_ncs = 1'b1; st0.p_ready = 1'b1;
    st1.rise_cyc = -1; st1.p_ncs = 1'b1; st1.p_ready = 1'b1;
    n_frames[0] = 0; n_frames[1] = 0;
    for (int i = 0; i < 2; i++) begin
      rst_w[i] = 1'b1; cv[i] = 1'b1; rw_v[i] = 1'b1;
      addr_v[i] = 7'h55; data_v[i] = 8'hAA;
    end

    // Reset held 3 cycles with cmd_valid high: reset must win every edge.
    for (int i = 0; i < 3; i++) begin
      tick(1);
      mon_en = 1'b1;
      check_idle(0, "rst");
      check_idle(1, "rst1");
    end
    rst_w[0] = 1'b0; rst_w[1] = 1'b0; cv[0] = 1'b0; cv[1] = 1'b0;
    tick(2);
    check_idle(0, "post_rst");

    // Single write 0x80A5.
    send(0, 1'b1, 7'h00, 8'hA5, 1'b1);
    cv[0] = 1'b0;
    wait_idle(0);

    // Back-to-back with cmd_valid held: ncs high exactly GAP+1 cycles.
    send(0, 1'b1, 7'h04, 8'hFF, 1'b1);
    send(0, 1'b1, 7'h01, 8'h3C, 1'b1);
    cv[0] = 1'b0;
    wait_idle(0);
    check("b2b_ncs_high", st0.last_gap, GAP + 1);

    // Command pulsed mid-frame is ignored.
    d_before = st0.dones;
    send(0, 1'b1, 7'h10, 8'h5A, 1'b1);
    cv[0] = 1'b0;
    tick(19);
    cv[0] = 1'b1; addr_v[0] = 7'h02; data_v[0] = 8'h11;
    tick(1);
    cv[0] = 1'b0;
    wait_idle(0);
    tick(200);
    check("ignored_one_done", st0.dones - d_before, 1);
    check("ignored_no_extra", exp0.size(), 0);

    // Reset mid-frame: immediate idle, no done, then a clean frame.
    d_before = st0.dones;
    send(0, 1'($urandom), 7'($urandom), 8'($urandom), 1'b0);
    cv[0] = 1'b0;
    tick(58);
    rst_w[0] = 1'b1;
    tick(1);
    check_idle(0, "abort");
    tick(1);
    rst_w[0] = 1'b0;
    tick(1);
    check("abort_ready", rdy[0], 1'b1);
    check("abort_no_done_cnt", st0.dones - d_before, 0);
    send(0, 1'($urandom), 7'($urandom), 8'($urandom), 1'b1);
    cv[0] = 1'b0;
    wait_idle(0);

    // Randomized frames, rw random (rw=0 shifted identically).
    for (int i = 0; i < 6; i++) begin
      send(0, 1'($urandom), 7'($urandom), 8'($urandom), 1'b1);
      cv[0] = 1'b0;
      tick($urandom_range(0, 5));
    end
    wait_idle(0);

    // CLK_DIV=1 instance.
    send(1, 1'b1, 7'h7F, 8'h00, 1'b1);
    cv[1] = 1'b0;
    wait_idle(1);
    for (int i = 0; i < 4; i++) begin
      send(1, 1'($urandom), 7'($urandom), 8'($urandom), 1'b1);
      if ($urandom_range(0, 1) == 0) cv[1] = 1'b0;
    end
    cv[1] = 1'b0;
    wait_idle(1);

    tick(10);
    check("exp0_drained", exp0.size(), 0);
    check("exp1_drained", exp1.size(), 0);
    check("done_count_0", st0.dones, n_frames[0]);
    check("done_count_1", st1.dones, n_frames[1]);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
